// File: rtl/pwconv_fmap_collector_if.sv
// Handshake bundle between the pwconv stage, the fmap collector and the DWConv stage.
// The slave modport is the collector's view; the master modport is its environment.
interface pwconv_fmap_collector_if #(
    parameter int DATA_W    = 8,
    parameter int PIXEL_NUM = 36,
    parameter int CH_NUM    = 32
);
    localparam int VEC_W  = PIXEL_NUM * DATA_W;
    localparam int TILE_W = CH_NUM * VEC_W;
    localparam int CNT_W  = $clog2(CH_NUM);

    logic              pw_valid_i;
    logic [VEC_W-1:0]  pw_pixel_i;
    logic              clear_i;
    logic              fmap_ready_i;
    logic              fmap_valid_o;
    logic [TILE_W-1:0] fmap_pixel_o;
    logic [CNT_W-1:0]  ch_cnt_o;
    logic              overflow_o;

    modport slave (
        input  pw_valid_i, pw_pixel_i, clear_i, fmap_ready_i,
        output fmap_valid_o, fmap_pixel_o, ch_cnt_o, overflow_o
    );

    modport master (
        output pw_valid_i, pw_pixel_i, clear_i, fmap_ready_i,
        input  fmap_valid_o, fmap_pixel_o, ch_cnt_o, overflow_o
    );
endinterface

// File: rtl/pwconv_fmap_collector.sv
// Ping-pong collector: gathers CH_NUM channel vectors per tile from pwconv and
// hands completed tiles to DWConv over valid/ready; dropped vectors set a sticky flag.
module pwconv_fmap_collector #(
    parameter int DATA_W    = 8,
    parameter int PIXEL_NUM = 36,
    parameter int CH_NUM    = 32
) (
    input logic                      clk,
    input logic                      rst_n,
    pwconv_fmap_collector_if.slave   bus
);
    localparam int VEC_W  = PIXEL_NUM * DATA_W;
    localparam int TILE_W = CH_NUM * VEC_W;
    localparam int CNT_W  = $clog2(CH_NUM);

    logic [VEC_W-1:0]  r_bank [2][CH_NUM];
    logic [1:0]        r_full;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [CNT_W-1:0]  r_ch_cnt;
    logic              r_overflow;

    logic              w_wr;
    logic              w_drop;
    logic              w_last;
    logic              w_xfer;
    logic [1:0]        w_full_nxt;
    logic [TILE_W-1:0] w_tile;

    // Decisions use registered full flags: a same-cycle transfer never rescues a write.
    assign w_wr   = bus.pw_valid_i & ~bus.clear_i & ~r_full[r_wr_bank];
    assign w_drop = bus.pw_valid_i & ~bus.clear_i &  r_full[r_wr_bank];
    assign w_last = (r_ch_cnt == CNT_W'(CH_NUM - 1));
    assign w_xfer = r_full[r_rd_bank] & bus.fmap_ready_i;

    always_comb begin
        w_full_nxt = r_full;
        if (w_xfer)
            w_full_nxt[r_rd_bank] = 1'b0;
        if (w_wr && w_last)
            w_full_nxt[r_wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_ch_cnt   <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clear_i) begin
            r_full     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_ch_cnt   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_xfer)
                r_rd_bank <= ~r_rd_bank;
            if (w_wr) begin
                if (w_last) begin
                    r_ch_cnt  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_ch_cnt  <= r_ch_cnt + 1'b1;
                end
            end
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    // Bank storage survives clear; only reset zeroes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < CH_NUM; c++)
                    r_bank[b][c] <= '0;
        end else if (w_wr) begin
            r_bank[r_wr_bank][r_ch_cnt] <= bus.pw_pixel_i;
        end
    end

    always_comb begin
        w_tile = '0;
        for (int c = 0; c < CH_NUM; c++)
            w_tile[c*VEC_W +: VEC_W] = r_bank[r_rd_bank][c];
    end

    assign bus.fmap_valid_o = r_full[r_rd_bank];
    assign bus.fmap_pixel_o = w_tile;
    assign bus.ch_cnt_o     = r_ch_cnt;
    assign bus.overflow_o   = r_overflow;
endmodule

// File: tb/tb_pwconv_fmap_collector.sv
// Scoreboard bench for pwconv_fmap_collector: directed scenarios then random traffic,
// checked against a tile-queue reference model.
module tb_pwconv_fmap_collector;
    localparam int DATA_W    = 8;
    localparam int PIXEL_NUM = 36;
    localparam int CH_NUM    = 32;
    localparam int VEC_W     = PIXEL_NUM * DATA_W;
    localparam int TILE_W    = CH_NUM * VEC_W;
    localparam int CNT_W     = $clog2(CH_NUM);

    logic clk;
    logic rst_n;

    pwconv_fmap_collector_if #(
        .DATA_W(DATA_W), .PIXEL_NUM(PIXEL_NUM), .CH_NUM(CH_NUM)
    ) bus ();

    pwconv_fmap_collector #(
        .DATA_W(DATA_W), .PIXEL_NUM(PIXEL_NUM), .CH_NUM(CH_NUM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: completed tiles awaiting delivery, plus the tile being assembled.
    logic [TILE_W-1:0] sb[$];
    logic [VEC_W-1:0]  m_cur [CH_NUM];
    int                m_pend;
    int                m_cnt;
    bit                m_ovf;
    int                n_chk;
    int                n_fail;
    int                n_tiles;

    function automatic logic [VEC_W-1:0] pat_vec(input int c, input int off);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int p = 0; p < PIXEL_NUM; p++)
            v[p*DATA_W +: DATA_W] = 8'(c + p + off);
        return v;
    endfunction

    function automatic logic [VEC_W-1:0] rnd_vec();
        logic [VEC_W-1:0] v;
        v = '0;
        for (int p = 0; p < PIXEL_NUM; p++)
            v[p*DATA_W +: DATA_W] = 8'($urandom);
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_tile(input string name, input logic [TILE_W-1:0] act,
                            input logic [TILE_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            for (int c = 0; c < CH_NUM; c++)
                if (act[c*VEC_W +: VEC_W] !== exp[c*VEC_W +: VEC_W]) begin
                    $display("FAIL %s: ch %0d got %h expected %h at %0t", name, c,
                             act[c*VEC_W +: VEC_W], exp[c*VEC_W +: VEC_W], $time);
                    break;
                end
        end
    endtask

    // One clock of stimulus; the model consumes the same inputs at the edge.
    task automatic step(input logic v, input logic [VEC_W-1:0] px,
                        input logic clr, input logic rdy, input logic rst);
        logic [TILE_W-1:0] t;
        bit                xfer;
        rst_n            = rst;
        bus.pw_valid_i   = v;
        bus.pw_pixel_i   = px;
        bus.clear_i      = clr;
        bus.fmap_ready_i = rdy;
        @(posedge clk);
        if (!rst) begin
            m_pend = 0; m_cnt = 0; m_ovf = 0; sb.delete();
        end else if (clr) begin
            m_pend = 0; m_cnt = 0; m_ovf = 0; sb.delete();
        end else begin
            xfer = (m_pend > 0) && rdy;
            if (v) begin
                if (m_pend == 2) begin
                    m_ovf = 1'b1;
                end else begin
                    m_cur[m_cnt] = px;
                    m_cnt++;
                    if (m_cnt == CH_NUM) begin
                        t = '0;
                        for (int c = 0; c < CH_NUM; c++)
                            t[c*VEC_W +: VEC_W] = m_cur[c];
                        sb.push_back(t);
                        m_pend++;
                        m_cnt = 0;
                    end
                end
            end
            if (xfer)
                m_pend--;
        end
        #1;
    endtask

    task automatic send_tile(input int off, input logic rdy);
        for (int c = 0; c < CH_NUM; c++)
            step(1'b1, pat_vec(c, off), 1'b0, rdy, 1'b1);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++)
            step(1'b0, '0, 1'b0, rdy, 1'b1);
    endtask

    // Monitor: samples mid-cycle, pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", longint'(bus.fmap_valid_o), 0);
            chk("rst_cnt", longint'(bus.ch_cnt_o), 0);
            chk("rst_ovf", longint'(bus.overflow_o), 0);
            chk("rst_pixel_zero", longint'(bus.fmap_pixel_o == '0), 1);
        end else begin
            chk("valid", longint'(bus.fmap_valid_o), longint'(m_pend > 0));
            chk("ch_cnt", longint'(bus.ch_cnt_o), longint'(m_cnt));
            chk("overflow", longint'(bus.overflow_o), longint'(m_ovf));
            if (bus.fmap_valid_o) begin
                if (sb.size() == 0) begin
                    chk("tile_expected", 0, 1);
                end else begin
                    chk_tile("tile", bus.fmap_pixel_o, sb[0]);
                    if (bus.fmap_ready_i) begin
                        void'(sb.pop_front());
                        n_tiles++;
                    end
                end
            end
        end
    end

    initial begin
        n_chk = 0; n_fail = 0; n_tiles = 0;
        m_pend = 0; m_cnt = 0; m_ovf = 0;
        rst_n = 1'b0;
        bus.pw_valid_i = 1'b0;
        bus.pw_pixel_i = '0;
        bus.clear_i = 1'b0;
        bus.fmap_ready_i = 1'b0;
        #2;
        step(1'b1, pat_vec(0, 7), 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Single tile streamed straight through.
        send_tile(0, 1'b1);
        idle(3, 1'b1);

        // Two tiles back-pressured, then released one at a time.
        send_tile(10, 1'b0);
        send_tile(20, 1'b0);
        idle(3, 1'b0);
        idle(1, 1'b1);
        idle(3, 1'b0);
        idle(2, 1'b1);

        // Overflow: third tile's first vector hits two full banks.
        send_tile(30, 1'b0);
        send_tile(40, 1'b0);
        step(1'b1, pat_vec(0, 50), 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        step(1'b1, pat_vec(0, 51), 1'b0, 1'b1, 1'b1);
        idle(3, 1'b1);
        send_tile(60, 1'b1);
        idle(2, 1'b1);

        // Last write into one bank coincides with transfer from the other.
        send_tile(70, 1'b0);
        for (int c = 0; c < CH_NUM - 1; c++)
            step(1'b1, pat_vec(c, 80), 1'b0, 1'b0, 1'b1);
        step(1'b1, pat_vec(CH_NUM - 1, 80), 1'b0, 1'b1, 1'b1);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Clear mid-tile with a colliding pulse, also clears sticky overflow.
        for (int c = 0; c < 10; c++)
            step(1'b1, pat_vec(c, 90), 1'b0, 1'b1, 1'b1);
        step(1'b1, pat_vec(10, 90), 1'b1, 1'b1, 1'b1);
        send_tile(100, 1'b1);
        idle(2, 1'b1);

        // Reset mid-tile, then a clean tile.
        for (int c = 0; c < 20; c++)
            step(1'b1, pat_vec(c, 110), 1'b0, 1'b1, 1'b1);
        step(1'b1, pat_vec(20, 110), 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        send_tile(120, 1'b1);
        idle(2, 1'b1);

        // Random traffic including drops racing transfers and occasional clears.
        for (int i = 0; i < 4000; i++)
            step(($urandom_range(0, 9) < 8), rnd_vec(),
                 ($urandom_range(0, 499) == 0), ($urandom_range(0, 3) == 0), 1'b1);
        idle(6, 1'b1);

        chk("tiles_delivered_min", longint'(n_tiles >= 10), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
